// File: rtl/fetch_pc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pc_ctrl_pkg
//   Shared definitions for the front-end fetch PC controller: the reset fetch
//   address, the controller state encoding and the small address helpers used
//   by the next-PC mux.
// ---------------------------------------------------------------------------
package fetch_pc_ctrl_pkg;

    // Default fetch address loaded on reset.
    localparam logic [31:0] PC_RESET = 32'h1C00_0000;

    // Controller states, held in a 2-bit state register.
    typedef enum logic [1:0] {
        FPC_BOOT = 2'b00,
        FPC_RUN  = 2'b01,
        FPC_IDLE = 2'b10
    } fpc_state_e;

    // Sequential successor of a fetch address: the fetch group is an aligned
    // 8-byte pair, so the next group starts at the next 8-byte boundary.
    // A PC in the upper word of a pair therefore advances by 4, otherwise by
    // 8, and the address wraps modulo 2^32.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return {pc[31:3] + 29'd1, 3'b000};
    endfunction

    // Redirect targets are instruction addresses; the two low bits are
    // dropped so a malformed target still fetches a whole word.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : fetch_pc_ctrl_pkg

// File: rtl/fetch_pc_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_pc_ctrl
//   Generates the fetch address for the IF0/IF1 stages. After reset the
//   controller spends one cycle in BOOT, then fetches sequential 8-byte
//   groups in RUN, accepting exception and branch redirects, and parks in
//   IDLE after an IDLE instruction until an interrupt wake-up or exception.
//
// Ports
//   clk          in   1   sole clock, all state on rising edge
//   rstn         in   1   asynchronous active-low reset
//   if0_ready    in   1   IF0/IF1 can accept a fetch this cycle
//   stall        in   1   front-end stall, fetch does not advance
//   exc_flush    in   1   exception / ertn redirect
//   exc_target   in  32   exception redirect target
//   br_flush     in   1   branch-mispredict redirect
//   br_target    in  32   branch redirect target
//   idle_req     in   1   IDLE instruction retiring, enter IDLE
//   wake         in   1   interrupt wake-up from IDLE
//   if0_valid    out  1   fetch_pc is a valid fetch request this cycle
//   fetch_pc     out 32   current fetch address
//   pc_next      out 32   sequential successor of fetch_pc
//   flush        out  1   clear the stage registers downstream
//   flush_cause  out  1   1 = exception flush, 0 = branch flush
// ---------------------------------------------------------------------------
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RST = PC_RESET
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if0_ready,
    input  logic        stall,
    input  logic        exc_flush,
    input  logic [31:0] exc_target,
    input  logic        br_flush,
    input  logic [31:0] br_target,
    input  logic        idle_req,
    input  logic        wake,
    output logic        if0_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] pc_next,
    output logic        flush,
    output logic        flush_cause
);

    fpc_state_e  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        fire;

    // ------------------------------------------------------------------
    // Combinational outputs. A redirect in flight suppresses the fetch of
    // the stale address in the same cycle.
    // ------------------------------------------------------------------
    assign flush       = exc_flush | br_flush;
    assign flush_cause = exc_flush;
    assign pc_next     = seq_pc(fetch_pc_q);
    assign fetch_pc    = fetch_pc_q;
    assign if0_valid   = (state_q == FPC_RUN) & ~stall & ~flush;
    assign fire        = if0_valid & if0_ready;

    // ------------------------------------------------------------------
    // Next-state and next-PC selection. Exception redirect outranks every
    // other request; branch redirects and idle requests only matter in RUN.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;

        unique case (state_q)
            FPC_BOOT: begin
                state_d = FPC_RUN;
                if (exc_flush) begin
                    fetch_pc_d = word_align(exc_target);
                end
            end

            FPC_RUN: begin
                if (exc_flush) begin
                    fetch_pc_d = word_align(exc_target);
                end else begin
                    if (br_flush) begin
                        fetch_pc_d = word_align(br_target);
                    end else if (fire) begin
                        fetch_pc_d = pc_next;
                    end
                    // The branch target still lands even when idling, so
                    // the wake-up resumes from the corrected path.
                    if (idle_req) begin
                        state_d = FPC_IDLE;
                    end
                end
            end

            FPC_IDLE: begin
                if (exc_flush) begin
                    fetch_pc_d = word_align(exc_target);
                    state_d    = FPC_RUN;
                end else if (wake) begin
                    state_d = FPC_RUN;
                end
            end

            default: begin
                // Unused encoding: restart cleanly as after reset.
                state_d    = FPC_BOOT;
                fetch_pc_d = PC_RST;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register. Reset drops any pending fetch or idle; nothing about
    // a redirect is held across cycles, so none can survive reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= FPC_BOOT;
            fetch_pc_q <= PC_RST;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // values from before the edge, independent of statement order.
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

endmodule : fetch_pc_ctrl

// File: tb/tb_fetch_pc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_ctrl
//   Directed bench for fetch_pc_ctrl. The driver applies one cycle of inputs
//   at a time and queues the hand-computed outputs expected for that cycle;
//   the monitor pops them at the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if0_ready;
    logic        stall;
    logic        exc_flush;
    logic [31:0] exc_target;
    logic        br_flush;
    logic [31:0] br_target;
    logic        idle_req;
    logic        wake;
    logic        if0_valid;
    logic [31:0] fetch_pc;
    logic [31:0] pc_next;
    logic        flush;
    logic        flush_cause;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] pcn;
        logic        valid;
        logic        fl;
        logic        fc;
    } exp_t;

    exp_t exp_q[$];

    fetch_pc_ctrl #(.PC_RST(32'h1C00_0000)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .if0_ready  (if0_ready),
        .stall      (stall),
        .exc_flush  (exc_flush),
        .exc_target (exc_target),
        .br_flush   (br_flush),
        .br_target  (br_target),
        .idle_req   (idle_req),
        .wake       (wake),
        .if0_valid  (if0_valid),
        .fetch_pc   (fetch_pc),
        .pc_next    (pc_next),
        .flush      (flush),
        .flush_cause(flush_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: compares whatever the driver queued for the current cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".fetch_pc"},    fetch_pc,            e.pc);
            check({e.name, ".pc_next"},     pc_next,             e.pcn);
            check({e.name, ".if0_valid"},   {31'd0, if0_valid},  {31'd0, e.valid});
            check({e.name, ".flush"},       {31'd0, flush},      {31'd0, e.fl});
            check({e.name, ".flush_cause"}, {31'd0, flush_cause},{31'd0, e.fc});
        end
    end

    // Queue the expectation for the inputs now applied, then advance a cycle.
    task automatic cyc(input string nm, input logic [31:0] pc, input logic [31:0] pcn,
                       input logic v, input logic fl, input logic fc);
        exp_t e;
        e.name = nm; e.pc = pc; e.pcn = pcn; e.valid = v; e.fl = fl; e.fc = fc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        exc_flush = 1'b0;
        br_flush  = 1'b0;
        idle_req  = 1'b0;
        wake      = 1'b0;
    endtask

    // Watchdog: the directed sequence is short; this only guards a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0; if0_ready = 1'b1; stall = 1'b0;
        exc_target = 32'h0; br_target = 32'h0;
        clear_req();
        @(posedge clk); #1;

        // Reset state; flush outputs still follow the inputs.
        cyc("reset", 32'h1C00_0000, 32'h1C00_0008, 0, 0, 0);
        br_flush = 1'b1; br_target = 32'h1C00_0500;
        cyc("reset_br", 32'h1C00_0000, 32'h1C00_0008, 0, 1, 0);
        exc_flush = 1'b1; exc_target = 32'h1C00_0600;
        cyc("reset_exc", 32'h1C00_0000, 32'h1C00_0008, 0, 1, 1);
        clear_req();

        // Boot one cycle, then sequential fetch.
        rstn = 1'b1;
        cyc("boot",  32'h1C00_0000, 32'h1C00_0008, 0, 0, 0);
        cyc("run0",  32'h1C00_0000, 32'h1C00_0008, 1, 0, 0);
        cyc("run1",  32'h1C00_0008, 32'h1C00_0010, 1, 0, 0);
        cyc("run2",  32'h1C00_0010, 32'h1C00_0018, 1, 0, 0);

        // Stall holds the PC; fetch resumes at the same address.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) cyc("stall", 32'h1C00_0018, 32'h1C00_0020, 0, 0, 0);
        stall = 1'b0;
        cyc("unstall", 32'h1C00_0018, 32'h1C00_0020, 1, 0, 0);

        // Branch redirect with IF0 not ready.
        if0_ready = 1'b0; br_flush = 1'b1; br_target = 32'h1C00_0104;
        cyc("br_redir", 32'h1C00_0020, 32'h1C00_0028, 0, 1, 0);
        clear_req();
        cyc("br_hold",  32'h1C00_0104, 32'h1C00_0108, 1, 0, 0);
        if0_ready = 1'b1;
        cyc("br_fire",  32'h1C00_0104, 32'h1C00_0108, 1, 0, 0);
        cyc("br_next",  32'h1C00_0108, 32'h1C00_0110, 1, 0, 0);

        // Exception beats branch in the same cycle.
        exc_flush = 1'b1; exc_target = 32'h1C00_8000;
        br_flush  = 1'b1; br_target  = 32'h1C00_0200;
        cyc("exc_pri", 32'h1C00_0110, 32'h1C00_0118, 0, 1, 1);
        clear_req();
        cyc("exc_land", 32'h1C00_8000, 32'h1C00_8008, 1, 0, 0);

        // Wrap at the top of the address space.
        br_flush = 1'b1; br_target = 32'hFFFF_FFF8;
        cyc("wrap_redir", 32'h1C00_8008, 32'h1C00_8010, 0, 1, 0);
        clear_req(); if0_ready = 1'b0;
        cyc("wrap_top",  32'hFFFF_FFF8, 32'h0000_0000, 1, 0, 0);
        if0_ready = 1'b1;
        cyc("wrap_fire", 32'hFFFF_FFF8, 32'h0000_0000, 1, 0, 0);
        if0_ready = 1'b0;
        cyc("wrap_zero", 32'h0000_0000, 32'h0000_0008, 1, 0, 0);

        // Misaligned target is word-aligned; upper word of a pair steps by 4.
        br_flush = 1'b1; br_target = 32'h1C00_0006;
        cyc("align_redir", 32'h0000_0000, 32'h0000_0008, 0, 1, 0);
        clear_req();
        cyc("align_land", 32'h1C00_0004, 32'h1C00_0008, 1, 0, 0);

        // Enter IDLE; PC frozen, branch and idle requests ignored.
        idle_req = 1'b1;
        cyc("idle_req", 32'h1C00_0004, 32'h1C00_0008, 1, 0, 0);
        clear_req(); if0_ready = 1'b1;
        for (int i = 0; i < 10; i++) cyc("idle", 32'h1C00_0004, 32'h1C00_0008, 0, 0, 0);
        br_flush = 1'b1; br_target = 32'h1C00_0300; idle_req = 1'b1;
        cyc("idle_br", 32'h1C00_0004, 32'h1C00_0008, 0, 1, 0);
        clear_req();
        cyc("idle_br_ign", 32'h1C00_0004, 32'h1C00_0008, 0, 0, 0);
        wake = 1'b1;
        cyc("wake", 32'h1C00_0004, 32'h1C00_0008, 0, 0, 0);
        clear_req();
        cyc("woke_run", 32'h1C00_0004, 32'h1C00_0008, 1, 0, 0);

        // Idle again and leave via exception.
        if0_ready = 1'b0; idle_req = 1'b1;
        cyc("idle2_req", 32'h1C00_0008, 32'h1C00_0010, 1, 0, 0);
        clear_req();
        cyc("idle2", 32'h1C00_0008, 32'h1C00_0010, 0, 0, 0);
        exc_flush = 1'b1; exc_target = 32'h1C00_A002;
        cyc("idle2_exc", 32'h1C00_0008, 32'h1C00_0010, 0, 1, 1);
        clear_req();
        cyc("idle2_out", 32'h1C00_A000, 32'h1C00_A008, 1, 0, 0);

        // Branch plus idle request: target lands, controller idles.
        br_flush = 1'b1; br_target = 32'h1C00_0400; idle_req = 1'b1;
        cyc("br_idle", 32'h1C00_A000, 32'h1C00_A008, 0, 1, 0);
        clear_req();
        cyc("br_idle_park", 32'h1C00_0400, 32'h1C00_0408, 0, 0, 0);
        wake = 1'b1;
        cyc("br_idle_wake", 32'h1C00_0400, 32'h1C00_0408, 0, 0, 0);
        clear_req(); if0_ready = 1'b1;
        cyc("br_idle_run", 32'h1C00_0400, 32'h1C00_0408, 1, 0, 0);

        // Reset mid-operation returns straight to BOOT at the reset PC.
        rstn = 1'b0;
        cyc("mid_reset", 32'h1C00_0000, 32'h1C00_0008, 0, 0, 0);
        rstn = 1'b1;
        cyc("mid_boot", 32'h1C00_0000, 32'h1C00_0008, 0, 0, 0);
        cyc("mid_run",  32'h1C00_0000, 32'h1C00_0008, 1, 0, 0);
        cyc("mid_run1", 32'h1C00_0008, 32'h1C00_0010, 1, 0, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_pc_ctrl
